be_dispatcher: RTL
==================

Name: be_dispatcher

Overview:
Back-end dispatch stage and producer side of the per-EU instruction queues. It accepts one renamed instruction per cycle from upstream with a valid/ready handshake and holds it in a one-entry register. Each cycle it steers the held instruction to exactly one eligible, non-full eu_IQueue using round-robin selection. It drives each queue's dispatched_instr_i / dispatched_instr_valid_i and observes each queue's is_full_o.

Parameters:
NUM_EUS, 4, number of execution units / IQueues fed (>=2)
LOG2_NUM_EUS, 2, $clog2(NUM_EUS); width of round-robin pointer
STALL_CNT_WIDTH, 16, width of saturating stall performance counter

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
instr_i  input  $bits(type_iqueue_entry)  instruction from rename stage
instr_eu_mask_i  input  NUM_EUS  bit k set = EU k may execute instr_i
instr_valid_i  input  1  instr_i/instr_eu_mask_i valid
instr_ready_o  output  1  dispatcher can accept instr_i this cycle
flush_i  input  1  pipeline flush; discard held instruction
eu_is_full_i  input  NUM_EUS  is_full_o of each EU's IQueue
dispatched_instr_o  output  $bits(type_iqueue_entry)  broadcast to every IQueue's dispatched_instr_i
dispatched_instr_valid_o  output  NUM_EUS  one-hot (or zero) write strobe per IQueue
bad_mask_o  output  1  sticky: an instruction with all-zero eu_mask was accepted
stall_cycles_o  output  STALL_CNT_WIDTH  cycles with held instr valid but no dispatch

Behaviour:
- One clock, clk. reset_n is asynchronous and active-low. Reset values: held_valid=0, held_instr=0, held_mask=0, rr_ptr=0, bad_mask_o=0, stall_cycles_o=0.
- Post-reset outputs: dispatched_instr_valid_o=0, instr_ready_o=1.
- Eligible set: elig = held_mask & ~eu_is_full_i, qualified by held_valid and ~flush_i.
- Selection: first set bit of elig, searched circularly from rr_ptr upward, wrapping NUM_EUS-1 -> 0. Combinational from registers plus eu_is_full_i.
- dispatched_instr_valid_o = onehot(sel) when elig != 0, else 0. Never more than one bit set.
- dispatched_instr_o = held_instr at all times; it is a don't-care when no strobe is set.
- dispatch_fire = |dispatched_instr_valid_o. The IQueue writes on the same clk edge.
- On dispatch_fire to EU k: rr_ptr <= (k+1) mod NUM_EUS. Otherwise rr_ptr holds.
- instr_ready_o = ~flush_i & (~held_valid | dispatch_fire). Accept = instr_valid_i & instr_ready_o.
- Accept loads held_instr/held_mask and sets held_valid=1. Accept and dispatch in the same cycle replace the held entry, giving a throughput of 1 instr/cycle.
- Dispatch without accept clears held_valid. Latency from accept to strobe is 1 cycle minimum.
- Zero mask: accepting instr_eu_mask_i==0 sets bad_mask_o (sticky until reset). The instruction is dropped: held_valid stays 0 for it and no strobe is ever issued.
- Full: if every eligible EU is full, hold the instruction, deassert instr_ready_o, and increment stall_cycles_o. The counter saturates at all-ones and does not wrap.
- flush_i=1: no strobe this cycle, held_valid <= 0, instr_ready_o=0, rr_ptr unchanged, stall counter not incremented. Flush has priority over dispatch and accept.
- eu_is_full_i may change every cycle; the dispatcher never strobes a queue whose full bit is high in that cycle.
- Reset asserted mid-stall: state clears immediately, and any held instruction is lost by design.

Decomposition:
- pkg_dtypes already provides type_iqueue_entry.
- Add to pkg_dtypes: localparam DISPATCH_STALL_CNT_WIDTH=16. No new struct: eu_mask stays a separate port so NUM_EUS is not baked into the package.
- One sub-module: rr_select (parameter N). Inputs req[N-1:0] and ptr; outputs grant one-hot and grant_idx. Purely combinational, reusable by the writeback arbiter.

Test Plan:
- Reset then idle: after reset release, instr_ready_o=1, dispatched_instr_valid_o=0, stall_cycles_o=0, bad_mask_o=0.
- Streaming, mask=4'b1111, all not full, 8 instrs back-to-back: strobes 0001,0010,0100,1000,0001,... on consecutive cycles; instr_ready_o stays 1; first strobe 1 cycle after first accept.
- Restricted mask with full queues: mask=4'b0110, eu_is_full_i=4'b0010 -> strobe 0100. Then eu_is_full_i=4'b0110 for 3 cycles -> strobe 0, ready=0, stall_cycles_o increments by 3. Release full -> strobe dispatches.
- Wrap and priority: rr_ptr=3 after a dispatch to EU2, mask=4'b1001, none full -> strobe 1000, then rr_ptr=0. Next instr with mask 4'b1001 -> strobe 0001.
- Flush while stalled: held instr, all full, flush_i=1 for one cycle -> no strobe, ready=0 that cycle. Next cycle held_valid=0, ready=1, and the old instruction is never dispatched.
- Zero mask and saturation: accept an instr with mask 4'b0000 -> bad_mask_o=1 the next cycle and stays 1, with no strobe. Force 65540 stall cycles -> stall_cycles_o=16'hFFFF.

Source files
------------

// File: rtl/pkg_dtypes.sv
// Shared back-end datatypes: the IQueue entry format and dispatch-stage constants.
package pkg_dtypes;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    logic [31:0] imm;
  } type_iqueue_entry;

  localparam int DISPATCH_STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/be_dispatcher_if.sv
// Rename-side handshake plus the per-EU IQueue write/full signals of the dispatcher.
interface be_dispatcher_if import pkg_dtypes::*; #(parameter int NUM_EUS = 4);

  type_iqueue_entry       instr_i;
  logic [NUM_EUS-1:0]     instr_eu_mask_i;
  logic                   instr_valid_i;
  logic                   instr_ready_o;
  logic [NUM_EUS-1:0]     eu_is_full_i;
  type_iqueue_entry       dispatched_instr_o;
  logic [NUM_EUS-1:0]     dispatched_instr_valid_o;

  modport master (
    input  instr_i, instr_eu_mask_i, instr_valid_i, eu_is_full_i,
    output instr_ready_o, dispatched_instr_o, dispatched_instr_valid_o
  );

  modport slave (
    output instr_i, instr_eu_mask_i, instr_valid_i, eu_is_full_i,
    input  instr_ready_o, dispatched_instr_o, dispatched_instr_valid_o
  );

endinterface

// File: rtl/be_dispatcher_rr_select.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping N-1 -> 0.
module rr_select #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  always_comb begin
    logic         found;
    logic [W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/be_dispatcher.sv
// Dispatch stage: one-entry holding register steered round-robin into non-full EU IQueues.
module be_dispatcher import pkg_dtypes::*; #(
  parameter int NUM_EUS         = 4,
  parameter int LOG2_NUM_EUS    = $clog2(NUM_EUS),
  parameter int STALL_CNT_WIDTH = DISPATCH_STALL_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  be_dispatcher_if.master            bus,
  input  logic                       flush_i,
  output logic                       bad_mask_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles_o
);

  logic                    held_valid;
  type_iqueue_entry        held_instr;
  logic [NUM_EUS-1:0]      held_mask;
  logic [LOG2_NUM_EUS-1:0] rr_ptr;

  logic [NUM_EUS-1:0]      elig;
  logic [NUM_EUS-1:0]      grant;
  logic [LOG2_NUM_EUS-1:0] grant_idx;
  logic                    dispatch_fire;
  logic                    accept;
  logic                    stall;

  // Flush masks eligibility so it overrides both dispatch and accept.
  assign elig = (held_valid && !flush_i) ? (held_mask & ~bus.eu_is_full_i) : '0;

  rr_select #(.N(NUM_EUS), .W(LOG2_NUM_EUS)) u_rr_select (
    .req       (elig),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign dispatch_fire                = |grant;
  assign bus.dispatched_instr_valid_o = grant;
  assign bus.dispatched_instr_o       = held_instr;
  assign bus.instr_ready_o            = !flush_i && (!held_valid || dispatch_fire);
  assign accept                       = bus.instr_valid_i && bus.instr_ready_o;
  assign stall                        = held_valid && !flush_i && !dispatch_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_valid <= 1'b0;
      held_instr <= '0;
      held_mask  <= '0;
    end else if (flush_i) begin
      held_valid <= 1'b0;
    end else if (accept) begin
      held_instr <= bus.instr_i;
      held_mask  <= bus.instr_eu_mask_i;
      // A zero mask has no legal target, so it is dropped rather than held forever.
      held_valid <= |bus.instr_eu_mask_i;
    end else if (dispatch_fire) begin
      held_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (dispatch_fire) begin
      rr_ptr <= (grant_idx == LOG2_NUM_EUS'(NUM_EUS - 1)) ? '0
                                                          : grant_idx + LOG2_NUM_EUS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_mask_o <= 1'b0;
    end else if (accept && (bus.instr_eu_mask_i == '0)) begin
      bad_mask_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_o <= '0;
    end else if (stall && (stall_cycles_o != '1)) begin
      stall_cycles_o <= stall_cycles_o + STALL_CNT_WIDTH'(1);
    end
  end

endmodule
